// File: rtl/aes_gcm_phase_sequencer.sv
// aes_gcm_phase_sequencer
// Issue controller for the AES-GCM encrypt pipeline. Accepts one GCM job at a
// time and issues one 128-bit beat per cycle into pipeline stage 1:
//   HKEY -> [AAD] -> DATA* -> LEN
// Each beat carries a phase code, CTR counter value and running instance size
// {len(A), len(C)} in bits. Owns the CTR counter and the length computation.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   i_start / o_start_ready   job handshake (ready in IDLE only)
//   i_iv, i_aad, i_aad_bytes, i_no_data   job descriptor, latched on accept
//   i_pt_data/valid/last/bytes, o_pt_ready   plaintext stream
//   i_pipe_ready        downstream accepts an issue this cycle
//   o_valid, o_phase, o_plain_text, o_aad, o_iv, o_ctr, o_instance_size,
//   o_done              registered beat outputs
//   o_error             sticky counter-overflow flag, cleared on next accept
module aes_gcm_phase_sequencer #(
  parameter logic [31:0] CTR_INIT = 32'd2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  output logic         o_start_ready,
  input  logic [0:95]  i_iv,
  input  logic [0:127] i_aad,
  input  logic [0:4]   i_aad_bytes,
  input  logic         i_no_data,
  input  logic [0:127] i_pt_data,
  input  logic         i_pt_valid,
  input  logic         i_pt_last,
  input  logic [0:4]   i_pt_bytes,
  output logic         o_pt_ready,
  input  logic         i_pipe_ready,
  output logic         o_valid,
  output logic [0:2]   o_phase,
  output logic [0:127] o_plain_text,
  output logic [0:127] o_aad,
  output logic [0:95]  o_iv,
  output logic [0:31]  o_ctr,
  output logic [0:127] o_instance_size,
  output logic         o_done,
  output logic         o_error
);

  typedef enum logic [2:0] {IDLE, HKEY, AAD, DATA, LEN} state_t;

  localparam logic [2:0] PH_HKEY = 3'd1;
  localparam logic [2:0] PH_AAD  = 3'd2;
  localparam logic [2:0] PH_DATA = 3'd3;
  localparam logic [2:0] PH_LEN  = 3'd4;

  // Registered beat presented to stage 2.
  typedef struct packed {
    logic         valid;
    logic [2:0]   phase;
    logic [127:0] payload;
    logic [127:0] aad;
    logic [95:0]  iv;
    logic [31:0]  ctr;
    logic [127:0] isz;
    logic         done;
  } beat_t;

  // Per-job context latched on accept and updated by DATA beats.
  typedef struct packed {
    logic [95:0]  iv;
    logic [127:0] aad;
    logic         has_aad;
    logic         no_data;
    logic [31:0]  ctr;
    logic [63:0]  len_a;
    logic [63:0]  len_c;
    logic         err;
  } job_t;

  state_t       state, state_n;
  job_t         job, job_n;
  beat_t        beat, beat_n;

  logic [4:0]   aad_nb, pt_nb;
  logic [127:0] aad_in, aad_mask;
  logic         ctr_ovf;

  // Byte 0 of the AAD is the most significant byte; bytes at or beyond the
  // clamped length are zeroed so the GHASH input is already padded.
  always_comb begin
    aad_nb   = (i_aad_bytes > 5'd16) ? 5'd16 : i_aad_bytes;
    aad_in   = i_aad;
    aad_mask = aad_in;
    for (int b = 0; b < 16; b++)
      if (5'(b) >= aad_nb) aad_mask[127-8*b -: 8] = 8'h00;
  end

  // Only the last plaintext beat can be partial.
  always_comb begin
    if (!i_pt_last)             pt_nb = 5'd16;
    else if (i_pt_bytes > 5'd16) pt_nb = 5'd16;
    else                         pt_nb = i_pt_bytes;
  end

  assign ctr_ovf = (job.ctr == 32'hFFFF_FFFF);

  always_comb begin
    state_n      = state;
    job_n        = job;
    beat_n       = beat;
    beat_n.valid = 1'b0;
    beat_n.done  = 1'b0;
    case (state)
      IDLE: if (i_start) begin
        job_n.iv      = i_iv;
        job_n.aad     = aad_mask;
        job_n.has_aad = (aad_nb != 5'd0);
        job_n.no_data = i_no_data;
        job_n.ctr     = CTR_INIT;
        job_n.len_a   = {56'd0, aad_nb, 3'b000};
        job_n.len_c   = 64'd0;
        job_n.err     = 1'b0;
        state_n       = HKEY;
      end
      HKEY: if (i_pipe_ready) begin
        beat_n.valid   = 1'b1;
        beat_n.phase   = PH_HKEY;
        beat_n.payload = 128'd0;
        beat_n.ctr     = 32'd0;
        if (job.has_aad)      state_n = AAD;
        else if (!job.no_data) state_n = DATA;
        else                  state_n = LEN;
      end
      AAD: if (i_pipe_ready) begin
        beat_n.valid   = 1'b1;
        beat_n.phase   = PH_AAD;
        beat_n.payload = job.aad;
        beat_n.ctr     = 32'd0;
        state_n        = job.no_data ? LEN : DATA;
      end
      DATA: if (i_pipe_ready && i_pt_valid) begin
        beat_n.valid   = 1'b1;
        beat_n.phase   = PH_DATA;
        beat_n.payload = i_pt_data;
        beat_n.ctr     = job.ctr;
        job_n.ctr      = job.ctr + 32'd1;
        job_n.len_c    = job.len_c + {56'd0, pt_nb, 3'b000};
        // The wrapped counter would reuse a keystream block: flag it and
        // close the job after this beat, dropping the rest of the stream.
        if (ctr_ovf) job_n.err = 1'b1;
        if (i_pt_last || ctr_ovf) state_n = LEN;
      end
      LEN: if (i_pipe_ready) begin
        beat_n.valid   = 1'b1;
        beat_n.phase   = PH_LEN;
        beat_n.payload = {job.len_a, job.len_c};
        beat_n.ctr     = 32'd1;
        beat_n.done    = 1'b1;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Side-band fields follow the job context; instance size includes the
    // length contributed by the beat being issued.
    if (beat_n.valid) begin
      beat_n.aad = job.aad;
      beat_n.iv  = job.iv;
      beat_n.isz = {job.len_a, job_n.len_c};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job  <= '0;
      beat <= '0;
    end else begin
      job  <= job_n;
      beat <= beat_n;
    end
  end

  assign o_start_ready   = (state == IDLE);
  assign o_pt_ready      = (state == DATA) && i_pipe_ready;
  assign o_valid         = beat.valid;
  assign o_phase         = beat.phase;
  assign o_plain_text    = beat.payload;
  assign o_aad           = beat.aad;
  assign o_iv            = beat.iv;
  assign o_ctr           = beat.ctr;
  assign o_instance_size = beat.isz;
  assign o_done          = beat.done;
  assign o_error         = job.err;

endmodule

// File: tb/tb_aes_gcm_phase_sequencer.sv
// Scoreboard bench for aes_gcm_phase_sequencer. Two instances share inputs:
// u_dut with the default counter start and u_ovf with the counter start near
// wrap; `sel` picks which one drives the handshakes and is scoreboarded.
module tb_aes_gcm_phase_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start, i_no_data, i_pt_valid, i_pt_last, i_pipe_ready;
  logic [95:0]  i_iv;
  logic [127:0] i_aad, i_pt_data;
  logic [4:0]   i_aad_bytes, i_pt_bytes;

  logic         sr1, pr1, v1, d1, e1, sr2, pr2, v2, d2, e2;
  logic [2:0]   ph1, ph2;
  logic [127:0] pl1, ad1, is1, pl2, ad2, is2;
  logic [95:0]  iv1, iv2;
  logic [31:0]  ct1, ct2;

  logic         sel;
  logic         m_start_ready, m_pt_ready, m_valid, m_done, m_error;
  logic [2:0]   m_phase;
  logic [127:0] m_pl, m_aad, m_isz;
  logic [95:0]  m_iv;
  logic [31:0]  m_ctr;

  always #5 clk = ~clk;

  aes_gcm_phase_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_start_ready(sr1),
    .i_iv(i_iv), .i_aad(i_aad), .i_aad_bytes(i_aad_bytes), .i_no_data(i_no_data),
    .i_pt_data(i_pt_data), .i_pt_valid(i_pt_valid), .i_pt_last(i_pt_last),
    .i_pt_bytes(i_pt_bytes), .o_pt_ready(pr1), .i_pipe_ready(i_pipe_ready),
    .o_valid(v1), .o_phase(ph1), .o_plain_text(pl1), .o_aad(ad1), .o_iv(iv1),
    .o_ctr(ct1), .o_instance_size(is1), .o_done(d1), .o_error(e1));

  aes_gcm_phase_sequencer #(.CTR_INIT(32'hFFFF_FFFE)) u_ovf (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_start_ready(sr2),
    .i_iv(i_iv), .i_aad(i_aad), .i_aad_bytes(i_aad_bytes), .i_no_data(i_no_data),
    .i_pt_data(i_pt_data), .i_pt_valid(i_pt_valid), .i_pt_last(i_pt_last),
    .i_pt_bytes(i_pt_bytes), .o_pt_ready(pr2), .i_pipe_ready(i_pipe_ready),
    .o_valid(v2), .o_phase(ph2), .o_plain_text(pl2), .o_aad(ad2), .o_iv(iv2),
    .o_ctr(ct2), .o_instance_size(is2), .o_done(d2), .o_error(e2));

  assign m_start_ready = sel ? sr2 : sr1;
  assign m_pt_ready    = sel ? pr2 : pr1;
  assign m_valid       = sel ? v2  : v1;
  assign m_done        = sel ? d2  : d1;
  assign m_error       = sel ? e2  : e1;
  assign m_phase       = sel ? ph2 : ph1;
  assign m_pl          = sel ? pl2 : pl1;
  assign m_aad         = sel ? ad2 : ad1;
  assign m_isz         = sel ? is2 : is1;
  assign m_iv          = sel ? iv2 : iv1;
  assign m_ctr         = sel ? ct2 : ct1;

  typedef struct {
    logic [2:0]   ph;
    logic [31:0]  ctr;
    logic [127:0] pl;
    logic [127:0] isz;
    logic [127:0] aad;
    logic [95:0]  iv;
    logic         done;
    logic         err;
  } beat_t;

  beat_t        q[$];
  logic [127:0] blk[$];
  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every issued beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (m_valid) begin
      if (q.size() == 0) chk("extra_beat", 1, 0);
      else begin
        beat_t e;
        e = q.pop_front();
        chk("phase", m_phase, e.ph);
        chk("ctr",   m_ctr,   e.ctr);
        chk("payld", m_pl,    e.pl);
        chk("isz",   m_isz,   e.isz);
        chk("aad",   m_aad,   e.aad);
        chk("iv",    m_iv,    e.iv);
        chk("done",  m_done,  e.done);
        chk("err",   m_error, e.err);
      end
      if (m_done) done_cnt++;
    end
  end

  task automatic push(input logic [2:0] ph, input logic [31:0] c, input logic [127:0] pl,
                      input logic [127:0] isz, input logic [127:0] ad, input logic [95:0] iv,
                      input logic dn, input logic er);
    beat_t b;
    b.ph = ph; b.ctr = c; b.pl = pl; b.isz = isz; b.aad = ad; b.iv = iv; b.done = dn; b.err = er;
    q.push_back(b);
  endtask

  task automatic run_job(input logic [95:0] iv, input logic [127:0] aad, input int ab,
                         input bit nd, input int n, input int lb, input bit rnd,
                         input bit hold, input bit abort);
    int           nb, k, dc0;
    logic [63:0]  la, lc;
    logic [31:0]  c;
    logic [127:0] maad;
    bit           er, accepted, fire, got_done, pr, pv;

    // Build the job's plaintext and expected beat sequence.
    blk.delete();
    for (int i = 0; i < n; i++) blk.push_back({$urandom, $urandom, $urandom, $urandom});
    nb   = (ab > 16) ? 16 : ab;
    la   = 64'(nb * 8);
    lc   = 64'd0;
    c    = sel ? 32'hFFFF_FFFE : 32'd2;
    er   = 1'b0;
    maad = aad;
    for (int b = 0; b < 16; b++) if (b >= nb) maad[127-8*b -: 8] = 8'h00;
    push(3'd1, 32'd0, 128'd0, {la, lc}, maad, iv, 1'b0, 1'b0);
    if (nb != 0) push(3'd2, 32'd0, maad, {la, lc}, maad, iv, 1'b0, 1'b0);
    if (!nd)
      for (int i = 0; i < n; i++) begin
        lc = lc + ((i == n - 1) ? 64'(8 * lb) : 64'd128);
        if (c == 32'hFFFF_FFFF) er = 1'b1;
        push(3'd3, c, blk[i], {la, lc}, maad, iv, 1'b0, er);
        if (er) break;
        c = c + 32'd1;
      end
    push(3'd4, 32'd1, {la, lc}, {la, lc}, maad, iv, 1'b1, er);

    i_iv = iv; i_aad = aad; i_aad_bytes = ab[4:0]; i_no_data = nd;
    k = 0; accepted = 0; got_done = 0; dc0 = done_cnt;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk); #1;
      if (m_done) begin got_done = 1; i_start = 1'b0; break; end
      pr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      pv = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_pipe_ready = pr;
      i_pt_valid   = pv && (k < n);
      i_pt_data    = (k < n) ? blk[k] : 128'd0;
      i_pt_last    = (k == n - 1);
      i_pt_bytes   = (k == n - 1) ? lb[4:0] : 5'd16;
      i_start      = hold ? 1'b1 : !accepted;
      #3;
      fire = m_pt_ready && i_pt_valid;
      if (i_start && m_start_ready && !accepted) accepted = 1;
      @(posedge clk);
      if (fire) k++;
      #1;
      if (!pr) chk("stall_vld", m_valid, 0);
      if (m_error) chk("ovf_ptrdy", m_pt_ready, 0);
      if (abort && k == 2) begin
        // Reset lands while the 2nd DATA beat is on the outputs.
        #1 rst_n = 1'b0;
        i_start = 1'b0; i_pt_valid = 1'b0;
        #1;
        chk("rst_vld",   m_valid, 0);
        chk("rst_phase", m_phase, 0);
        chk("rst_payld", m_pl, 0);
        chk("rst_ctr",   m_ctr, 0);
        chk("rst_isz",   m_isz, 0);
        chk("rst_done",  m_done, 0);
        chk("rst_srdy",  m_start_ready, 1);
        q.delete();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_srdy2", m_start_ready, 1);
        chk("rst_prdy",  m_pt_ready, 0);
        chk("rst_nodone", done_cnt, dc0);
        return;
      end
    end
    i_start = 1'b0; i_pt_valid = 1'b0; i_pipe_ready = 1'b1;
    chk("job_done", got_done, 1);
    chk("q_empty", q.size(), 0);
    chk("done_cnt", done_cnt, dc0 + 1);
    chk("srdy_after", m_start_ready, 1);
    chk("prdy_after", m_pt_ready, 0);
    if (sel) chk("ovf_taken", k, 2);
    q.delete();
  endtask

  initial begin
    sel = 1'b0; rst_n = 1'b1;
    i_start = 0; i_no_data = 0; i_pt_valid = 0; i_pt_last = 0; i_pipe_ready = 0;
    i_iv = '0; i_aad = '0; i_pt_data = '0; i_aad_bytes = '0; i_pt_bytes = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("r_valid", v1, 0);
    chk("r_phase", ph1, 0);
    chk("r_done",  d1, 0);
    chk("r_err",   e1, 0);
    chk("r_ctr",   ct1, 0);
    chk("r_isz",   is1, 0);
    chk("r_srdy",  sr1, 1);
    chk("r_prdy",  pr1, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Full AAD, three full blocks.
    run_job(96'hCAFEBABE_DEADBEEF_01234567, {$urandom, $urandom, $urandom, $urandom},
            16, 0, 3, 16, 0, 0, 0);
    // No AAD, partial last block (len(C) = 128 + 40).
    run_job(96'h1, 128'h0, 0, 0, 2, 5, 0, 0, 0);
    // No data, 7-byte AAD, start held through the job.
    run_job(96'h2, {$urandom, $urandom, $urandom, $urandom}, 7, 1, 0, 16, 0, 1, 0);
    // Random stalls over ten blocks.
    run_job(96'h3, {$urandom, $urandom, $urandom, $urandom}, 3, 0, 10, 12, 1, 0, 0);
    // Over-range AAD length clamps to 16, single 1-byte block.
    run_job(96'h4, {$urandom, $urandom, $urandom, $urandom}, 20, 0, 1, 1, 0, 0, 0);
    // Reset during the job, then a clean job.
    run_job(96'h5, 128'h0, 0, 0, 3, 16, 0, 0, 1);
    run_job(96'h6, {$urandom, $urandom, $urandom, $urandom}, 9, 0, 3, 16, 0, 0, 0);
    // Counter overflow on the near-wrap instance.
    sel = 1'b1;
    run_job(96'h7, 128'h0, 0, 0, 4, 16, 0, 0, 0);
    chk("ovf_err_hold", e2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_gcm_phase_sequencer.md
# aes_gcm_phase_sequencer

Issue controller for the AES-GCM encrypt pipeline. It accepts one GCM job at a time and issues one 128-bit beat per cycle into the first pipeline stage: a hash-key beat, an optional AAD beat, the plaintext blocks, and a final length beat. Each beat is tagged with a phase code, a CTR counter value and the running instance size. It sits between the host/DMA plaintext stream and pipeline stage 2, and owns the CTR counter and the len(A)||len(C) computation.

## Interface
- CTR_INIT, 32'd2: counter value of the first data block. J0 = IV||1 is used by the length beat.
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- i_start  input  1  job request
- o_start_ready  output  1  high in IDLE only; job accepted when i_start & o_start_ready
- i_iv  input  [0:95]  job IV, latched on accept
- i_aad  input  [0:127]  single AAD block, latched on accept
- i_aad_bytes  input  [0:4]  AAD length 0..16; 0 skips the AAD phase; values >16 are treated as 16
- i_no_data  input  1  job has zero plaintext blocks; skips DATA
- i_pt_data  input  [0:127]  plaintext block
- i_pt_valid  input  1  plaintext beat valid
- i_pt_last  input  1  last plaintext block of the job
- i_pt_bytes  input  [0:4]  valid bytes 1..16 on the last beat; ignored (treated as 16) otherwise
- o_pt_ready  output  1  combinational: (state==DATA) & i_pipe_ready
- i_pipe_ready  input  1  downstream accepts an issue this cycle
- o_valid  output  1  registered beat strobe
- o_phase  output  [0:2]  0 none, 1 HKEY, 2 AAD, 3 DATA, 4 LEN
- o_plain_text  output  [0:127]  beat payload
- o_aad  output  [0:127]  latched AAD, zero-masked beyond i_aad_bytes
- o_iv  output  [0:95]  latched IV
- o_ctr  output  [0:31]  CTR counter for this beat
- o_instance_size  output  [0:127]  {len(A) bits 64, len(C) bits 64}; final on the LEN beat
- o_done  output  1  one-cycle pulse coincident with the LEN beat
- o_error  output  1  sticky counter-overflow flag; cleared on the next job accept

## Operation
- FSM states: IDLE, HKEY, AAD, DATA, LEN.
- Accept in IDLE:
  - Latch iv, the masked aad, aad_bytes and no_data.
  - Set ctr = CTR_INIT and len(C) = 0.
  - Set len(A) = 8*aad_bytes.
  - Clear o_error.
  - Go to HKEY.
- Issue condition for every beat: i_pipe_ready=1. DATA additionally needs i_pt_valid=1.
- When the issue condition fails, no state change and o_valid=0.
- HKEY beat: payload 128'd0, ctr 0. Next state is AAD if aad_bytes≠0; else DATA if !no_data; else LEN.
- AAD beat: payload = masked aad, ctr 0. Next state is DATA if !no_data, else LEN.
- DATA beat:
  - Payload = i_pt_data, o_ctr = ctr.
  - Then ctr += 1 and len(C) += 128, or += 8*i_pt_bytes on the last beat.
  - The running len(C) is 64-bit and wraps.
  - On i_pt_last, go to LEN.
- Counter overflow: a DATA beat issued with ctr=32'hFFFFFFFF sets o_error and still issues that beat. The FSM then forces LEN at the next issue opportunity; any remaining plaintext is not accepted by this job.
- LEN beat: payload = {len(A),len(C)}, o_ctr = 32'd1 (J0 tag block), o_done=1. Then go to IDLE.
- o_aad, o_iv and o_instance_size reflect the latched/running values on every beat.
- i_start is ignored outside IDLE.

## Timing
- All outputs except o_pt_ready and o_start_ready are registered.
- Reset values: o_valid 0, o_phase 0, o_done 0, o_error 0, all data outputs 0, state IDLE. So o_start_ready=1 and o_pt_ready=0.
- A beat issued at edge N is visible from edge N until edge N+1.
- With i_pipe_ready held high, an accept at edge T gives:
  - HKEY at T+1
  - AAD at T+2
  - the first DATA beat at T+3
- Throughput is 1 beat/cycle with no bubbles while the issue condition holds.
- Minimum job: no AAD, no data. Sequence is HKEY, then LEN; o_start_ready is high again the cycle after LEN.
- A new job can be accepted at the edge after the LEN beat. There is no overlap of jobs.
- If i_pt_valid and i_pipe_ready both drop mid-DATA, beats simply resume without loss. ctr and len(C) advance only on issued beats.
- rst_n asserted mid-job: immediate return to the reset values. The in-flight job is discarded and no o_done is produced.

## Test plan
- Job with iv=96'hCAFEBABE…, aad_bytes=16, 3 full PT blocks, pipe_ready=1:
  - beats are HKEY, AAD, DATA ctr 2/3/4, LEN ctr 1
  - instance_size = {64'd128, 64'd384}
  - o_done only on LEN
- Job with aad_bytes=0, 2 blocks, last i_pt_bytes=5: AAD phase skipped; len(C)=168; LEN instance_size = {64'd0, 64'd168}.
- Job with i_no_data=1, aad_bytes=7: HKEY, AAD (bytes 7..15 zeroed), then LEN {64'd56, 64'd0}. i_start asserted during the job is ignored.
- Random i_pipe_ready and i_pt_valid gaps over a 10-block job: ctr is contiguous 2..11 with no duplicate or dropped beat, and o_valid=0 on stall cycles.
- Force ctr to 32'hFFFFFFFE via the CTR_INIT override and send 4 blocks: 2 DATA beats issue, o_error=1, LEN follows, and o_pt_ready is low afterwards.
- Assert rst_n low at the 2nd DATA beat: outputs go to 0 asynchronously; after release o_start_ready=1 and a new job runs correctly from HKEY.
